// File: rtl/ret_marker_injector_pkg.sv
// Shared types and helpers for the return-marker CFI path: a trimmed
// scoreboard entry, the return predicate, marker defaults and the injector
// FSM state enum.
package ret_marker_injector_pkg;

   localparam int unsigned VLEN          = 64;
   localparam int unsigned XLEN          = 64;
   localparam int unsigned REG_ADDR_SIZE = 6;

   typedef enum logic [3:0] {
      NONE, LOAD, STORE, ALU, CTRL_FLOW, MULT, CSR
   } fu_t;

   typedef enum logic [7:0] {
      ADD, SUB, ADDW, XORL, ORL, ANDL, JALR, EQ, NE
   } fu_op;

   typedef struct packed {
      logic [XLEN-1:0] cause;
      logic [XLEN-1:0] tval;
      logic            valid;
   } exception_t;

   typedef struct packed {
      logic [VLEN-1:0]          pc;
      fu_t                      fu;
      fu_op                     op;
      logic [REG_ADDR_SIZE-1:0] rs1;
      logic [REG_ADDR_SIZE-1:0] rs2;
      logic [REG_ADDR_SIZE-1:0] rd;
      logic [XLEN-1:0]          result;
      logic                     valid;
      logic                     use_imm;
      logic                     use_zimm;
      logic                     use_pc;
      exception_t               ex;
      logic                     is_compressed;
   } scoreboard_entry_t;

   // Marker defaults: ADD x0, x0, 1
   localparam fu_op       DEF_NOP_OP  = ADD;
   localparam logic [4:0] DEF_NOP_RD  = 5'd0;
   localparam logic [4:0] DEF_NOP_RS1 = 5'd0;
   localparam logic [4:0] DEF_NOP_IMM = 5'd1;

   typedef enum logic [1:0] {
      ST_PASS     = 2'd0,
      ST_RET_OUT  = 2'd1,
      ST_MARK_OUT = 2'd2
   } ret_fsm_state_e;

   // A return is JALR x0, 0(x1) without a pending exception.
   function automatic logic is_ret(scoreboard_entry_t e);
      return (e.op == JALR) && (e.rd[4:0] == 5'd0) &&
             (e.rs1[4:0] == 5'd1) && !e.ex.valid;
   endfunction

endpackage

// File: rtl/ret_marker_gen.sv
// Combinational builder of the synthetic marker entry that follows a return.
// Only the return's pc is carried over; every other field is fixed.
module ret_marker_gen
   import ret_marker_injector_pkg::*;
#(
   parameter fu_op       NOP_OP  = DEF_NOP_OP,
   parameter logic [4:0] NOP_RD  = DEF_NOP_RD,
   parameter logic [4:0] NOP_RS1 = DEF_NOP_RS1,
   parameter logic [4:0] NOP_IMM = DEF_NOP_IMM
) (
   input  logic [VLEN-1:0]   pc_i,
   output scoreboard_entry_t marker_o
);

   // Zero everything, then fill in the marker fields
   always_comb begin
      marker_o         = '0;
      marker_o.pc      = pc_i;
      marker_o.fu      = ALU;
      marker_o.op      = NOP_OP;
      marker_o.rd      = REG_ADDR_SIZE'(NOP_RD);
      marker_o.rs1     = REG_ADDR_SIZE'(NOP_RS1);
      marker_o.result  = XLEN'(NOP_IMM);
      marker_o.use_imm = 1'b1;
   end

endmodule

// File: rtl/ret_marker_injector.sv
// One-entry registered stage that inserts a marker (ADD x0, x0, 1) after
// every valid return on the scoreboard-entry stream.
// Optional feature macro: ARIANE_RET_MARKER_CNT_EN enables the injection
// counter; without it inject_count_o is tied to zero and no counter flops
// exist.
module ret_marker_injector
   import ret_marker_injector_pkg::*;
#(
   parameter fu_op        NOP_OP  = DEF_NOP_OP,
   parameter logic [4:0]  NOP_RD  = DEF_NOP_RD,
   parameter logic [4:0]  NOP_RS1 = DEF_NOP_RS1,
   parameter logic [4:0]  NOP_IMM = DEF_NOP_IMM,
   parameter int unsigned CNT_W   = 32
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              flush_i,
   input  logic              entry_valid_i,
   output logic              entry_ready_o,
   input  scoreboard_entry_t entry_i,
   output logic              entry_valid_o,
   input  logic              entry_ready_i,
   output scoreboard_entry_t entry_o,
   output logic [CNT_W-1:0]  inject_count_o,
   output ret_fsm_state_e    state_o
);

   // Handshake: a transfer happens on a clock edge where valid && ready are
   // both high. A producer holding valid keeps its data stable until the
   // transfer and never withdraws valid except on flush or reset; ready may
   // depend combinationally on the consumer side.

   ret_fsm_state_e    state_q, state_d;
   logic              out_valid_q, out_valid_d;
   scoreboard_entry_t out_entry_q, out_entry_d;
   scoreboard_entry_t marker_entry;
   logic              up_accept;
   logic              dn_accept;

   // Upstream is only taken in PASS when the output slot frees up this cycle
   assign entry_ready_o = rst_ni && !flush_i && (state_q == ST_PASS) &&
                          (!out_valid_q || entry_ready_i);
   assign up_accept     = entry_valid_i && entry_ready_o;
   assign dn_accept     = out_valid_q && entry_ready_i;

   assign entry_valid_o = out_valid_q;
   assign entry_o       = out_entry_q;
   assign state_o       = state_q;

   // In RET_OUT the output register holds the return, so its pc seeds the marker
   ret_marker_gen #(
      .NOP_OP  (NOP_OP),
      .NOP_RD  (NOP_RD),
      .NOP_RS1 (NOP_RS1),
      .NOP_IMM (NOP_IMM)
   ) u_marker_gen (
      .pc_i     (out_entry_q.pc),
      .marker_o (marker_entry)
   );

   // Next-state and output-register update; flush overrides any acceptance
   always_comb begin
      state_d     = state_q;
      out_valid_d = out_valid_q;
      out_entry_d = out_entry_q;
      if (flush_i) begin
         state_d     = ST_PASS;
         out_valid_d = 1'b0;
      end else begin
         unique case (state_q)
            ST_PASS: begin
               if (up_accept) begin
                  out_valid_d = 1'b1;
                  out_entry_d = entry_i;
                  if (is_ret(entry_i)) state_d = ST_RET_OUT;
               end else if (dn_accept) begin
                  out_valid_d = 1'b0;
               end
            end
            ST_RET_OUT: begin
               if (dn_accept) begin
                  out_entry_d = marker_entry;
                  state_d     = ST_MARK_OUT;
               end
            end
            ST_MARK_OUT: begin
               if (dn_accept) begin
                  out_valid_d = 1'b0;
                  state_d     = ST_PASS;
               end
            end
            default: begin
               state_d     = ST_PASS;
               out_valid_d = 1'b0;
            end
         endcase
      end
   end

   // State and output register
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= ST_PASS;
         out_valid_q <= 1'b0;
         out_entry_q <= '0;
      end else begin
         state_q     <= state_d;
         out_valid_q <= out_valid_d;
         out_entry_q <= out_entry_d;
      end
   end

`ifdef ARIANE_RET_MARKER_CNT_EN
   logic [CNT_W-1:0] cnt_q;
   logic             mark_done;

   // A marker counts only when it actually leaves, never on a flush cycle
   assign mark_done = !flush_i && (state_q == ST_MARK_OUT) && dn_accept;

   // Wrapping injection counter, kept across flushes
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else if (mark_done) begin
         cnt_q <= cnt_q + CNT_W'(1);
      end
   end

   assign inject_count_o = cnt_q;
`else
   assign inject_count_o = '0;
`endif

endmodule

// File: tb/tb_ret_marker_injector.sv
// Bench for ret_marker_injector: directed scenarios plus a randomized run,
// all checked against an in-order expected stream built from the return rule.
module tb_ret_marker_injector;
   import ret_marker_injector_pkg::*;

   localparam int CNT_W = 32;
   localparam int EW    = $bits(scoreboard_entry_t);

   logic              clk = 1'b0;
   logic              rst_ni = 1'b0;
   logic              flush_i = 1'b0;
   logic              entry_valid_i = 1'b0;
   logic              entry_ready_i = 1'b0;
   scoreboard_entry_t entry_i = '0;
   logic              entry_ready_o;
   logic              entry_valid_o;
   scoreboard_entry_t entry_o;
   logic [CNT_W-1:0]  inject_count_o;
   ret_fsm_state_e    state_o;

   int vectors     = 0;
   int miscompares = 0;
   int markers_seen = 0;

   // Expected downstream stream; top bit flags a marker entry
   logic [EW:0]       exp_q[$];
   logic [CNT_W-1:0]  exp_cnt = '0;

   logic              s_ready, s_valid;
   scoreboard_entry_t s_entry;
   logic [CNT_W-1:0]  s_cnt;
   ret_fsm_state_e    s_state;
   logic              prev_hold = 1'b0;
   scoreboard_entry_t prev_entry = '0;

   ret_marker_injector #(.CNT_W(CNT_W)) dut (
      .clk_i          (clk),
      .rst_ni         (rst_ni),
      .flush_i        (flush_i),
      .entry_valid_i  (entry_valid_i),
      .entry_ready_o  (entry_ready_o),
      .entry_i        (entry_i),
      .entry_valid_o  (entry_valid_o),
      .entry_ready_i  (entry_ready_i),
      .entry_o        (entry_o),
      .inject_count_o (inject_count_o),
      .state_o        (state_o)
   );

   // Clock
   always #5 clk = ~clk;

   // Watchdog
   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   // ---------------- reference model ----------------
   function automatic logic ref_is_ret(scoreboard_entry_t e);
      if (e.ex.valid) return 1'b0;
      return (e.op == JALR) && (e.rd[4:0] == 5'd0) && (e.rs1[4:0] == 5'd1);
   endfunction

   function automatic scoreboard_entry_t ref_marker(scoreboard_entry_t r);
      scoreboard_entry_t m;
      m         = '0;
      m.pc      = r.pc;
      m.fu      = ALU;
      m.op      = ADD;
      m.result  = 64'd1;
      m.use_imm = 1'b1;
      return m;
   endfunction

   function automatic logic [CNT_W-1:0] ref_count();
      logic [CNT_W-1:0] r;
      r = exp_cnt;
`ifndef ARIANE_RET_MARKER_CNT_EN
      r = '0;
`endif
      return r;
   endfunction

   function automatic logic [CNT_W-1:0] exp_after(logic [CNT_W-1:0] base, int n);
      logic [CNT_W-1:0] r;
      r = base + CNT_W'(n);
`ifndef ARIANE_RET_MARKER_CNT_EN
      r = '0;
`endif
      return r;
   endfunction

   function automatic scoreboard_entry_t mk_entry(logic [63:0] pc, fu_t fu, fu_op op,
                                                  logic [5:0] rd, logic [5:0] rs1,
                                                  logic [5:0] rs2, logic [63:0] result,
                                                  logic use_imm);
      scoreboard_entry_t e;
      e         = '0;
      e.pc      = pc;
      e.fu      = fu;
      e.op      = op;
      e.rd      = rd;
      e.rs1     = rs1;
      e.rs2     = rs2;
      e.result  = result;
      e.use_imm = use_imm;
      e.valid   = 1'b1;
      return e;
   endfunction

   function automatic scoreboard_entry_t rand_entry();
      scoreboard_entry_t e;
      int k;
      e               = '0;
      e.pc            = {$urandom, $urandom};
      e.rs2           = 6'($urandom);
      e.result        = {$urandom, $urandom};
      e.use_pc        = 1'($urandom);
      e.is_compressed = 1'($urandom);
      e.valid         = 1'($urandom);
      k = $urandom_range(0, 9);
      if (k < 4) begin
         e.fu  = CTRL_FLOW;
         e.op  = JALR;
         e.rd  = {1'($urandom), 5'd0};
         e.rs1 = {1'($urandom), 5'd1};
      end else if (k < 6) begin
         e.fu  = CTRL_FLOW;
         e.op  = JALR;
         e.rd  = 6'($urandom_range(0, 3));
         e.rs1 = 6'($urandom_range(0, 3));
      end else begin
         e.fu  = ALU;
         e.op  = (k % 2 == 0) ? ADD : SUB;
         e.rd  = 6'($urandom);
         e.rs1 = 6'($urandom);
      end
      if ($urandom_range(0, 9) == 0) begin
         e.ex.valid = 1'b1;
         e.ex.cause = {$urandom, $urandom};
      end
      return e;
   endfunction

   // ---------------- driver / scoreboard ----------------
   // Inputs are set before the call; samples settle #1 into the low phase,
   // updates the expected stream, then moves to the next falling edge.
   task automatic cycle();
      logic [EW:0] head;
      #1;
      s_ready = entry_ready_o;
      s_valid = entry_valid_o;
      s_entry = entry_o;
      s_cnt   = inject_count_o;
      s_state = state_o;

      vectors++;
      if (inject_count_o !== ref_count()) begin
         miscompares++;
         $display("FAIL count: got %0d want %0d", inject_count_o, ref_count());
      end

      if (prev_hold) begin
         vectors++;
         if (entry_valid_o !== 1'b1 || entry_o !== prev_entry) begin
            miscompares++;
            $display("FAIL hold_stable: got v=%b %h want v=1 %h", entry_valid_o, entry_o, prev_entry);
         end
      end

      if (flush_i) begin
         exp_q.delete();
         vectors++;
         if (entry_ready_o !== 1'b0) begin
            miscompares++;
            $display("FAIL flush_ready: got %b want 0", entry_ready_o);
         end
      end else begin
         if (entry_valid_o && entry_ready_i) begin
            vectors++;
            if (exp_q.size() == 0) begin
               miscompares++;
               $display("FAIL unexpected_out: got %h want nothing", entry_o);
            end else begin
               head = exp_q.pop_front();
               if (entry_o !== head[EW-1:0]) begin
                  miscompares++;
                  $display("FAIL stream: got %h want %h", entry_o, head[EW-1:0]);
               end
               if (head[EW]) begin
                  markers_seen++;
                  exp_cnt++;
               end
            end
         end
         if (entry_valid_i && entry_ready_o) begin
            exp_q.push_back({1'b0, entry_i});
            if (ref_is_ret(entry_i)) exp_q.push_back({1'b1, ref_marker(entry_i)});
         end
      end

      prev_hold  = entry_valid_o && !entry_ready_i && !flush_i;
      prev_entry = entry_o;
      @(negedge clk);
   endtask

   task automatic drain();
      entry_valid_i = 1'b0;
      entry_ready_i = 1'b1;
      flush_i       = 1'b0;
      for (int i = 0; i < 12 && exp_q.size() > 0; i++) cycle();
      vectors++;
      if (exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL drain: got %0d entries left want 0", exp_q.size());
      end
   endtask

   task automatic chk(string name, logic [EW-1:0] got, logic [EW-1:0] want);
      vectors++;
      if (got !== want) begin
         miscompares++;
         $display("FAIL %s: got %h want %h", name, got, want);
      end
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      rst_ni        = 1'b0;
      entry_valid_i = 1'b1;
      entry_ready_i = 1'b1;
      entry_i       = rand_entry();
      repeat (2) @(negedge clk);
      #1;
      chk("reset_valid", EW'(entry_valid_o), EW'(0));
      chk("reset_entry", entry_o, '0);
      chk("reset_ready", EW'(entry_ready_o), EW'(0));
      chk("reset_count", EW'(inject_count_o), EW'(0));
      chk("reset_state", EW'(state_o), EW'(ST_PASS));
      @(negedge clk);
      entry_valid_i = 1'b0;
      rst_ni        = 1'b1;
      exp_q.delete();
      exp_cnt   = '0;
      prev_hold = 1'b0;
   endtask

   task automatic test_passthrough();
      scoreboard_entry_t sent[4];
      entry_ready_i = 1'b1;
      for (int i = 0; i < 4; i++) begin
         sent[i] = mk_entry(64'h1000 + 64'(4 * i), ALU, ADD, 6'(i + 1), 6'd2, 6'd0, 64'(3 * i), 1'b1);
         entry_valid_i = 1'b1;
         entry_i       = sent[i];
         cycle();
         chk("pass_ready", EW'(s_ready), EW'(1));
         if (i > 0) begin
            chk("pass_valid", EW'(s_valid), EW'(1));
            chk("pass_latency", s_entry, sent[i-1]);
         end
      end
      entry_valid_i = 1'b0;
      cycle();
      chk("pass_last", s_entry, sent[3]);
      chk("pass_count_zero", EW'(s_cnt), EW'(0));
      drain();
   endtask

   task automatic test_return();
      scoreboard_entry_t r, a, m;
      logic [CNT_W-1:0] base;
      base = exp_cnt;
      r = mk_entry(64'h8000_0100, CTRL_FLOW, JALR, 6'd0, 6'd1, 6'd0, 64'd0, 1'b0);
      a = mk_entry(64'h8000_0104, ALU, ADD, 6'd5, 6'd6, 6'd7, 64'd0, 1'b0);
      m = '0;
      m.pc = 64'h8000_0100; m.fu = ALU; m.op = ADD; m.result = 64'd1; m.use_imm = 1'b1;
      entry_ready_i = 1'b1;
      entry_valid_i = 1'b1;
      entry_i       = r;
      cycle();
      chk("ret_accept", EW'(s_ready), EW'(1));
      entry_i = a;
      cycle();
      chk("ret_out", s_entry, r);
      chk("ret_bubble1", EW'(s_ready), EW'(0));
      cycle();
      chk("ret_marker", s_entry, m);
      chk("ret_bubble2", EW'(s_ready), EW'(0));
      cycle();
      chk("ret_ready_back", EW'(s_ready), EW'(1));
      chk("ret_gap", EW'(s_valid), EW'(0));
      chk("ret_count", EW'(s_cnt), EW'(exp_after(base, 1)));
      entry_valid_i = 1'b0;
      cycle();
      chk("ret_follow", s_entry, a);
      drain();
   endtask

   task automatic test_exc_return();
      scoreboard_entry_t r;
      logic [CNT_W-1:0] base;
      base = exp_cnt;
      r = mk_entry(64'h8000_0200, CTRL_FLOW, JALR, 6'd0, 6'd1, 6'd0, 64'd0, 1'b0);
      r.ex.valid = 1'b1;
      r.ex.cause = 64'd12;
      entry_ready_i = 1'b1;
      entry_valid_i = 1'b1;
      entry_i       = r;
      cycle();
      entry_valid_i = 1'b0;
      cycle();
      chk("exc_out", s_entry, r);
      chk("exc_not_blocked", EW'(s_ready), EW'(1));
      cycle();
      chk("exc_no_marker", EW'(s_valid), EW'(0));
      chk("exc_count", EW'(s_cnt), EW'(exp_after(base, 0)));
      drain();
   endtask

   task automatic test_stall();
      scoreboard_entry_t r, a;
      r = mk_entry(64'h8000_0300, CTRL_FLOW, JALR, 6'd0, 6'd1, 6'd0, 64'd0, 1'b0);
      a = mk_entry(64'h8000_0304, ALU, SUB, 6'd9, 6'd10, 6'd11, 64'd0, 1'b0);
      entry_ready_i = 1'b1;
      entry_valid_i = 1'b1;
      entry_i       = r;
      cycle();
      entry_i = a;
      for (int i = 0; i < 4; i++) begin
         entry_ready_i = (i == 3);
         cycle();
         chk("stall_ret", s_entry, r);
         chk("stall_ready", EW'(s_ready), EW'(0));
      end
      cycle();
      chk("stall_marker", s_entry, ref_marker(r));
      chk("stall_marker_ready", EW'(s_ready), EW'(0));
      cycle();
      chk("stall_resume", EW'(s_ready), EW'(1));
      drain();
   endtask

   task automatic test_back_to_back();
      scoreboard_entry_t r1, r2;
      r1 = mk_entry(64'h8000_0500, CTRL_FLOW, JALR, 6'd0, 6'd1, 6'd0, 64'd0, 1'b0);
      r2 = mk_entry(64'h8000_0504, CTRL_FLOW, JALR, 6'd32, 6'd33, 6'd0, 64'd0, 1'b0);
      entry_ready_i = 1'b1;
      entry_valid_i = 1'b1;
      entry_i       = r1;
      cycle();
      entry_i = r2;
      cycle();
      chk("b2b_wait1", EW'(s_ready), EW'(0));
      cycle();
      chk("b2b_wait2", EW'(s_ready), EW'(0));
      cycle();
      chk("b2b_second", EW'(s_ready), EW'(1));
      drain();
   endtask

   task automatic test_flush();
      scoreboard_entry_t r, r2;
      logic [CNT_W-1:0] base;
      int m0;
      base = exp_cnt;
      r  = mk_entry(64'h8000_0400, CTRL_FLOW, JALR, 6'd0, 6'd1, 6'd0, 64'd0, 1'b0);
      r2 = mk_entry(64'h8000_0480, CTRL_FLOW, JALR, 6'd0, 6'd1, 6'd0, 64'd0, 1'b0);
      entry_ready_i = 1'b1;
      entry_valid_i = 1'b1;
      entry_i       = r;
      cycle();
      entry_valid_i = 1'b0;
      cycle();
      flush_i = 1'b1;
      cycle();
      chk("flush_marker_held", s_entry, ref_marker(r));
      chk("flush_state_mark", EW'(s_state), EW'(ST_MARK_OUT));
      flush_i = 1'b0;
      cycle();
      chk("flush_valid", EW'(s_valid), EW'(0));
      chk("flush_state", EW'(s_state), EW'(ST_PASS));
      chk("flush_count", EW'(s_cnt), EW'(exp_after(base, 0)));
      m0 = markers_seen;
      entry_valid_i = 1'b1;
      entry_i       = r2;
      cycle();
      drain();
      cycle();
      chk("flush_next_marker", EW'(markers_seen - m0), EW'(1));
      chk("flush_next_count", EW'(s_cnt), EW'(exp_after(base, 1)));
   endtask

   task automatic test_three_returns();
      logic [CNT_W-1:0] base;
      scoreboard_entry_t r;
      int m0;
      base = exp_cnt;
      m0   = markers_seen;
      for (int i = 0; i < 3; i++) begin
         r = mk_entry({$urandom, $urandom}, CTRL_FLOW, JALR, 6'd0, 6'd1, 6'd0, 64'd0, 1'b0);
         entry_valid_i = 1'b1;
         entry_ready_i = 1'b1;
         entry_i       = r;
         cycle();
         drain();
      end
      cycle();
      chk("three_markers", EW'(markers_seen - m0), EW'(3));
      chk("three_count", EW'(s_cnt), EW'(exp_after(base, 3)));
   endtask

   task automatic test_random();
      entry_valid_i = 1'b0;
      for (int i = 0; i < 400; i++) begin
         if (!(entry_valid_i && !s_ready)) begin
            entry_valid_i = ($urandom_range(0, 99) < 70);
            entry_i       = rand_entry();
         end
         entry_ready_i = ($urandom_range(0, 99) < 75);
         flush_i       = ($urandom_range(0, 99) < 3);
         cycle();
      end
      drain();
   endtask

   task automatic test_async_reset();
      scoreboard_entry_t r;
      r = mk_entry(64'h8000_0600, CTRL_FLOW, JALR, 6'd0, 6'd1, 6'd0, 64'd0, 1'b0);
      entry_ready_i = 1'b1;
      entry_valid_i = 1'b1;
      entry_i       = r;
      cycle();
      entry_valid_i = 1'b0;
      #2;
      rst_ni = 1'b0;
      #1;
      chk("areset_valid", EW'(entry_valid_o), EW'(0));
      chk("areset_entry", entry_o, '0);
      chk("areset_state", EW'(state_o), EW'(ST_PASS));
      chk("areset_count", EW'(inject_count_o), EW'(0));
      @(negedge clk);
      rst_ni = 1'b1;
      exp_q.delete();
      exp_cnt   = '0;
      prev_hold = 1'b0;
      entry_valid_i = 1'b1;
      entry_i       = r;
      cycle();
      drain();
   endtask

   initial begin
      test_reset();
      test_passthrough();
      test_return();
      test_exc_return();
      test_stall();
      test_back_to_back();
      test_flush();
      test_three_returns();
      test_random();
      test_async_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
